// File: rtl/touch_pkg.sv
// Shared types and default parameters for the touch button controller.
package touch_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARMING    = 3'd1,
        HELD      = 3'd2,
        LONG      = 3'd3,
        DISARMING = 3'd4
    } touch_state_e;

    localparam int DEB_N_DEF    = 4;
    localparam int LONG_N_DEF   = 200;
    localparam int REPEAT_N_DEF = 50;

endpackage

// File: rtl/touch_sample_cnt.sv
// Saturating sample counter with clear, load and increment; priority clear > load > inc.
module touch_sample_cnt #(
    parameter int W    = 8,
    parameter int MAX  = 1,
    parameter int LOAD = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_V  = W'(MAX);
    localparam logic [W-1:0] LOAD_V = W'(LOAD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_V;
        end else if (inc && (count < MAX_V)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/touch_button_ctrl.sv
// Debounces a sampled touch-hit stream into press/release/long events and a toggle level.
// Optional auto-repeat press pulses while held long: define TOUCH_BUTTON_AUTOREPEAT_EN.
module touch_button_ctrl
    import touch_pkg::*;
#(
    parameter int DEB_N    = DEB_N_DEF,
    parameter int LONG_N   = LONG_N_DEF,
    parameter int REPEAT_N = REPEAT_N_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sample_valid,
    input  logic         hit,
    output logic         pressed,
    output logic         press_pulse,
    output logic         release_pulse,
    output logic         long_pulse,
    output logic         toggle,
    output touch_state_e dbg_state
);

    if (DEB_N < 1 || DEB_N > 255 || LONG_N <= DEB_N || LONG_N > 65535 ||
        REPEAT_N < 1 || REPEAT_N > 65535) begin : g_bad_params
        $error("touch_button_ctrl: parameter out of range");
    end

    localparam logic [7:0]  RUN_LAST  = 8'(DEB_N - 1);
    localparam logic [15:0] HOLD_LAST = 16'(LONG_N - 1);
    localparam logic [15:0] HOLD_TOP  = 16'(LONG_N);

    touch_state_e state, state_next;

    logic        run_clr, run_load, run_inc;
    logic        hold_clr, hold_load, hold_inc;
    logic [7:0]  run_cnt;
    logic [15:0] hold_cnt;
    logic        press_ev, release_ev, long_ev, repeat_ev;

    // Run counter serves both the arming streak and the release streak.
    touch_sample_cnt #(.W(8), .MAX(DEB_N), .LOAD(1)) u_run_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (run_clr),
        .load  (run_load),
        .inc   (run_inc),
        .count (run_cnt)
    );

    touch_sample_cnt #(.W(16), .MAX(LONG_N), .LOAD(DEB_N)) u_hold_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (hold_clr),
        .load  (hold_load),
        .inc   (hold_inc),
        .count (hold_cnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        run_clr    = 1'b0;
        run_load   = 1'b0;
        run_inc    = 1'b0;
        hold_clr   = 1'b0;
        hold_load  = 1'b0;
        hold_inc   = 1'b0;
        press_ev   = 1'b0;
        release_ev = 1'b0;
        long_ev    = 1'b0;
        if (sample_valid) begin
            unique case (state)
                IDLE: begin
                    if (hit) begin
                        if (DEB_N == 1) begin
                            state_next = HELD;
                            press_ev   = 1'b1;
                            hold_load  = 1'b1;
                        end else begin
                            state_next = ARMING;
                            run_load   = 1'b1;
                        end
                    end
                end
                ARMING: begin
                    if (!hit) begin
                        state_next = IDLE;
                        run_clr    = 1'b1;
                    end else if (run_cnt >= RUN_LAST) begin
                        state_next = HELD;
                        press_ev   = 1'b1;
                        run_clr    = 1'b1;
                        hold_load  = 1'b1;
                    end else begin
                        run_inc = 1'b1;
                    end
                end
                HELD, LONG: begin
                    if (hit) begin
                        if (state == HELD) begin
                            hold_inc = 1'b1;
                            if (hold_cnt >= HOLD_LAST) begin
                                state_next = LONG;
                                long_ev    = 1'b1;
                            end
                        end
                    end else if (DEB_N == 1) begin
                        state_next = IDLE;
                        release_ev = 1'b1;
                        hold_clr   = 1'b1;
                    end else begin
                        state_next = DISARMING;
                        run_load   = 1'b1;
                    end
                end
                DISARMING: begin
                    // The hold counter only saturates at LONG_N, so it records where we came from.
                    if (hit) begin
                        state_next = (hold_cnt >= HOLD_TOP) ? LONG : HELD;
                        run_clr    = 1'b1;
                    end else if (run_cnt >= RUN_LAST) begin
                        state_next = IDLE;
                        release_ev = 1'b1;
                        run_clr    = 1'b1;
                        hold_clr   = 1'b1;
                    end else begin
                        run_inc = 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    run_clr    = 1'b1;
                    hold_clr   = 1'b1;
                end
            endcase
        end
    end

`ifdef TOUCH_BUTTON_AUTOREPEAT_EN
    localparam logic [15:0] REP_LAST = 16'(REPEAT_N - 1);

    logic        rep_clr, rep_inc;
    logic [15:0] rep_cnt;

    always_comb begin
        rep_clr   = release_ev;
        rep_inc   = 1'b0;
        repeat_ev = 1'b0;
        if (sample_valid && hit && (state == LONG)) begin
            if (rep_cnt >= REP_LAST) begin
                repeat_ev = 1'b1;
                rep_clr   = 1'b1;
            end else begin
                rep_inc = 1'b1;
            end
        end
    end

    touch_sample_cnt #(.W(16), .MAX(REPEAT_N), .LOAD(0)) u_rep_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (rep_clr),
        .load  (1'b0),
        .inc   (rep_inc),
        .count (rep_cnt)
    );
`else
    assign repeat_ev = 1'b0;
`endif

    // Repeats reuse press_pulse but leave the toggle level alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            toggle        <= 1'b0;
        end else begin
            press_pulse   <= press_ev | repeat_ev;
            release_pulse <= release_ev;
            long_pulse    <= long_ev;
            if (press_ev) begin
                pressed <= 1'b1;
                toggle  <= ~toggle;
            end else if (release_ev) begin
                pressed <= 1'b0;
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: doc/touch_button_ctrl.md
TOUCH_BUTTON_CTRL -- requirements
Module: touch_button_ctrl

Interface
REQ-001 SHALL have parameter DEB_N, default 4: consecutive agreeing samples needed to change the debounced state (range 1..255).
REQ-002 SHALL have parameter LONG_N, default 200: pressed samples, counted from the debounced press, before long_pulse (range DEB_N+1..65535).
REQ-003 SHALL have parameter REPEAT_N, default 50: samples between auto-repeat pulses (range 1..65535; used only with the macro).
REQ-004 SHALL have port clk  input  1  system clock, all state on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-006 SHALL have port sample_valid  input  1  one-clock strobe marking a fresh touch-region decision.
REQ-007 SHALL have port hit  input  1  touch-region result from the upstream rectangle-hit stage; read only when sample_valid=1.
REQ-008 SHALL have port pressed  output  1  debounced button level.
REQ-009 SHALL have port press_pulse  output  1  one-clock pulse on debounced press.
REQ-010 SHALL have port release_pulse  output  1  one-clock pulse on debounced release.
REQ-011 SHALL have port long_pulse  output  1  one-clock pulse when the hold reaches LONG_N.
REQ-012 SHALL have port toggle  output  1  level that inverts on every press_pulse.

Function
REQ-013 SHALL implement FSM states IDLE, ARMING, HELD, LONG, DISARMING; a transition occurs only on a clock with sample_valid=1.
REQ-014 IDLE: hit=1 -> ARMING with run counter=1; hit=0 -> stay.
REQ-015 ARMING: hit=1 increments the counter; when it reaches DEB_N -> HELD; hit=0 -> IDLE, no pulse, counter cleared.
REQ-016 With DEB_N=1, IDLE -> HELD SHALL occur on the first hit sample, skipping ARMING.
REQ-017 On entry to HELD: press_pulse=1 and toggle inverted on the next clock, pressed=1, hold counter=DEB_N.
REQ-018 HELD: hit=1 increments the hold counter; when it reaches LONG_N -> LONG with long_pulse=1 for one clock; hit=0 -> DISARMING with release counter=1.
REQ-019 LONG: hit=1 stays; hit=0 -> DISARMING.
REQ-020 DISARMING: hit=0 increments the release counter; at DEB_N -> IDLE with release_pulse=1 for one clock and pressed=0; hit=1 returns to the state it came from (HELD or LONG), keeping the hold counter.
REQ-021 Counters SHALL saturate at their terminal value and never wrap; the hold counter is 16 bits.
REQ-022 All outputs SHALL be registered; each pulse rises exactly one clock after the completing sample_valid edge and lasts one clock, even if sample_valid is held high.
REQ-023 press_pulse and release_pulse SHALL never assert in the same clock; with sample_valid=0, state and outputs hold, and pulses return to 0.

Reset
REQ-024 reset=0 SHALL asynchronously force state IDLE, all counters 0, and pressed, press_pulse, release_pulse, long_pulse, toggle all 0.
REQ-025 Reset asserted mid-press SHALL produce no release_pulse; after deassertion, a hit stream restarts from ARMING.

Configuration
REQ-026 Macro TOUCH_BUTTON_AUTOREPEAT_EN defined: in LONG, press_pulse SHALL fire once every REPEAT_N hit samples, first at LONG_N+REPEAT_N; toggle does not change on repeats.
REQ-027 Macro undefined: LONG emits no further pulses and the repeat counter is absent from the logic.

Structure
REQ-028 Shared package touch_pkg SHALL hold the state enum/encoding and the default DEB_N, LONG_N, REPEAT_N constants.
REQ-029 One sub-module, touch_sample_cnt, SHALL implement the parameterised saturating counter with clear and increment-on-sample enable, instantiated for the run, hold and repeat counters.

Verification (DEB_N=4, LONG_N=8, REPEAT_N=3)
REQ-030 Hit samples 1,1,1,0 then 0s -> no press_pulse, pressed stays 0.
REQ-031 4 hit samples -> press_pulse one clock after the 4th strobe, pressed=1, toggle 0->1; then 4 zero samples -> release_pulse, pressed=0.
REQ-032 8 continuous hit samples -> long_pulse after the 8th; with the macro defined, further press_pulse after the 11th and 14th; without it, none.
REQ-033 In HELD, samples 0,0,1 then 0,0,0,0 -> no release until the 4th consecutive zero; hold counter preserved.
REQ-034 reset asserted while pressed=1 -> all outputs 0 at once, no release_pulse; sample_valid held high 10 clocks with hit=1 -> exactly one press_pulse.
